// File: rtl/multi_ch_seq_sched_if.sv
// Serial channel bundle: per-channel valid/bit offered by the
// sources and a one-hot ready returned by the scheduler.
interface multi_ch_seq_sched_if;
    logic [3:0] ch_valid;
    logic [3:0] ch_bit;
    logic [3:0] ch_ready;

    modport master (
        output ch_valid,
        output ch_bit,
        input  ch_ready
    );

    modport slave (
        input  ch_valid,
        input  ch_bit,
        output ch_ready
    );
endinterface

// File: rtl/multi_ch_seq_sched.sv
// Four serial channels time-share one overlapping 4-bit pattern
// matcher; a round-robin arbiter accepts at most one bit per cycle.
module multi_ch_seq_sched (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    multi_ch_seq_sched_if.slave    ch_if,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_pattern,
    input  logic                   cnt_clr,
    input  logic [1:0]             cnt_sel,
    output logic                   match_valid,
    output logic [1:0]             match_ch,
    output logic [7:0]             cnt_out
);

    logic [3:0]      pattern_q, pattern_d;
    logic [3:0][2:0] hist_q, hist_d;
    logic [3:0][1:0] fill_q, fill_d;
    logic [1:0]      last_grant_q, last_grant_d;
    logic [3:0][7:0] cnt_q, cnt_d;
    logic            match_valid_q, match_valid_d;
    logic [1:0]      match_ch_q, match_ch_d;

    logic            gnt_found;
    logic [1:0]      gnt_idx;
    logic [1:0]      cand;
    logic            gnt_bit;
    logic            hit;

    // Search starts one past the last granted channel
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = last_grant_q;
        cand      = last_grant_q;
        if (!reset && enable && !cfg_we) begin
            for (int k = 1; k <= 4; k++) begin
                cand = last_grant_q + 2'(k);
                if (!gnt_found && ch_if.ch_valid[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    assign ch_if.ch_ready = gnt_found ? (4'b0001 << gnt_idx) : 4'b0000;
    assign gnt_bit = ch_if.ch_bit[gnt_idx];
    assign hit = gnt_found && (fill_q[gnt_idx] == 2'd3) &&
                 ({hist_q[gnt_idx], gnt_bit} == pattern_q);

    always_comb begin
        pattern_d     = pattern_q;
        hist_d        = hist_q;
        fill_d        = fill_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        match_valid_d = 1'b0;
        match_ch_d    = match_ch_q;

        if (gnt_found) begin
            hist_d[gnt_idx] = {hist_q[gnt_idx][1:0], gnt_bit};
            if (fill_q[gnt_idx] != 2'd3) begin
                fill_d[gnt_idx] = fill_q[gnt_idx] + 2'd1;
            end
            last_grant_d  = gnt_idx;
            match_valid_d = hit;
            match_ch_d    = gnt_idx;
            if (hit && cnt_q[gnt_idx] != 8'hff) begin
                cnt_d[gnt_idx] = cnt_q[gnt_idx] + 8'd1;
            end
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end

        // Histories are left stale; zero fill masks them until refilled
        if (cfg_we) begin
            pattern_d = cfg_pattern;
            fill_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q     <= 4'b1001;
            hist_q        <= '0;
            fill_q        <= '0;
            last_grant_q  <= 2'd3;
            cnt_q         <= '0;
            match_valid_q <= 1'b0;
            match_ch_q    <= 2'd0;
        end else begin
            pattern_q     <= pattern_d;
            hist_q        <= hist_d;
            fill_q        <= fill_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            match_valid_q <= match_valid_d;
            match_ch_q    <= match_ch_d;
        end
    end

    assign match_valid = match_valid_q;
    assign match_ch    = match_ch_q;
    assign cnt_out     = cnt_q[cnt_sel];

endmodule

// File: tb/tb_multi_ch_seq_sched.sv
// Bench for multi_ch_seq_sched: directed scenarios plus random
// traffic, checked against a bit-stream reference model.
module tb_multi_ch_seq_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       cfg_we;
    logic [3:0] cfg_pattern;
    logic       cnt_clr;
    logic [1:0] cnt_sel;
    logic       match_valid;
    logic [1:0] match_ch;
    logic [7:0] cnt_out;

    multi_ch_seq_sched_if ch_if ();

    always #5 clk = ~clk;

    multi_ch_seq_sched dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .ch_if       (ch_if),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cnt_clr     (cnt_clr),
        .cnt_sel     (cnt_sel),
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .cnt_out     (cnt_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: last bits seen as an integer window plus a
    // count of bits accepted since the last reset/reconfiguration
    int m_pat;
    int m_lg;
    int m_win [4];
    int m_n   [4];
    int m_ctr [4];
    int m_mv;
    int m_mch;

    logic [31:0] sq [4];
    int          sl [4];
    int          sp [4];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick();
        int c;
        if (reset || !enable || cfg_we) return -1;
        for (int k = 1; k <= 4; k++) begin
            c = (m_lg + k) % 4;
            if (ch_if.ch_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pat = 9;
        m_lg  = 3;
        m_mv  = 0;
        m_mch = 0;
        for (int i = 0; i < 4; i++) begin
            m_win[i] = 0;
            m_n[i]   = 0;
            m_ctr[i] = 0;
        end
    endtask

    task automatic drive(logic [3:0] v, logic [3:0] b, logic en,
                         logic we, logic [3:0] pat, logic clr,
                         logic [1:0] sel);
        ch_if.ch_valid = v;
        ch_if.ch_bit   = b;
        enable         = en;
        cfg_we         = we;
        cfg_pattern    = pat;
        cnt_clr        = clr;
        cnt_sel        = sel;
    endtask

    // Called just after a falling edge with inputs applied
    task automatic step(output int g);
        int b;
        int hit;
        #1;
        g = pick();
        check("ch_ready", ch_if.ch_ready, (g < 0) ? 0 : (1 << g));
        check("cnt_out", cnt_out, m_ctr[cnt_sel]);
        @(posedge clk);
        hit = 0;
        if (g >= 0) begin
            b = int'(ch_if.ch_bit[g]);
            m_win[g] = (m_win[g] * 2 + b) % 16;
            m_n[g]++;
            hit = (m_n[g] >= 4 && m_win[g] == m_pat) ? 1 : 0;
            m_lg  = g;
            m_mch = g;
            if (hit == 1 && m_ctr[g] < 255) m_ctr[g]++;
        end
        m_mv = hit;
        if (cnt_clr) for (int i = 0; i < 4; i++) m_ctr[i] = 0;
        if (cfg_we) begin
            m_pat = int'(cfg_pattern);
            for (int i = 0; i < 4; i++) m_n[i] = 0;
        end
        #1;
        check("match_valid", match_valid, m_mv);
        if (m_mv == 1) check("match_ch", match_ch, m_mch);
        @(negedge clk);
    endtask

    task automatic hard_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_ready", ch_if.ch_ready, 0);
        check("rst_match_valid", match_valid, 0);
        check("rst_match_ch", match_ch, 0);
        check("rst_cnt_out", cnt_out, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_seq();
        int g;
        int n;
        logic [3:0] v;
        logic [3:0] b;
        for (int i = 0; i < 4; i++) sp[i] = 0;
        n = 0;
        while ((sp[0] < sl[0] || sp[1] < sl[1] || sp[2] < sl[2] ||
                sp[3] < sl[3]) && n < 100) begin
            for (int i = 0; i < 4; i++) begin
                v[i] = (sp[i] < sl[i]);
                b[i] = v[i] ? sq[i][sp[i]] : 1'b0;
            end
            drive(v, b, 1'b1, 1'b0, cfg_pattern, 1'b0, cnt_sel);
            step(g);
            if (g >= 0) sp[g]++;
            n++;
        end
        if (n >= 100) check("seq_timeout", 1, 0);
    endtask

    task automatic set_seq(logic [31:0] s0, int l0, logic [31:0] s1, int l1,
                           logic [31:0] s2, int l2, logic [31:0] s3, int l3);
        sq[0] = s0; sl[0] = l0;
        sq[1] = s1; sl[1] = l1;
        sq[2] = s2; sl[2] = l2;
        sq[3] = s3; sl[3] = l3;
    endtask

    task automatic peek(string tag, logic [1:0] sel, int exp);
        cnt_sel = sel;
        #1;
        check(tag, cnt_out, exp);
    endtask

    initial begin
        int g;
        drive(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
        hard_reset();

        // Default pattern 1001 on ch0: matches on bits 4 and 7
        set_seq(32'b1001001, 7, 0, 0, 0, 0, 0, 0);
        run_seq();
        peek("single_cnt", 2'd0, 2);

        // Fairness from reset: strict rotation starting at ch0
        #2;
        hard_reset();
        for (int k = 0; k < 8; k++) begin
            drive(4'hf, 4'($urandom), 1'b1, 1'b0, cfg_pattern, 1'b0, 2'd0);
            step(g);
            check("fair_order", g, k % 4);
        end

        // Interleaved ch1 (1001) and ch2 (1111)
        drive(4'h0, 4'h0, 1'b1, 1'b0, cfg_pattern, 1'b1, 2'd0);
        step(g);
        set_seq(0, 0, 32'b1001, 4, 32'b1111, 4, 0, 0);
        run_seq();
        peek("intl_ch1", 2'd1, 1);
        peek("intl_ch2", 2'd2, 0);

        // Reconfigure to 1111 with traffic present: no grant that cycle
        drive(4'hf, 4'hf, 1'b1, 1'b1, 4'b1111, 1'b0, 2'd3);
        step(g);
        check("cfg_nogrant", g, -1);
        drive(4'h0, 4'h0, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd3);
        step(g);
        set_seq(0, 0, 0, 0, 0, 0, 32'b111111, 6);
        run_seq();
        peek("cfg_ch3", 2'd3, 3);

        // Counter saturation then clear on a matching cycle
        for (int k = 0; k < 303; k++) begin
            drive(4'h1, 4'h1, 1'b1, 1'b0, 4'b1111, 1'b0, 2'd0);
            step(g);
        end
        peek("sat_255", 2'd0, 255);
        drive(4'h1, 4'h1, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd0);
        step(g);
        check("clr_with_match", m_mv, 1);
        peek("clr_zero", 2'd0, 0);

        // Enable low: no grants, state held
        for (int k = 0; k < 3; k++) begin
            drive(4'hf, 4'($urandom), 1'b0, 1'b0, 4'b1111, 1'b0, 2'($urandom));
            step(g);
        end

        // Reset with a match in flight, then mid-pattern reset
        #2;
        hard_reset();
        set_seq(32'b1001, 4, 0, 0, 0, 0, 0, 0);
        run_seq();
        check("pre_rst_mv", match_valid, 1);
        #2;
        hard_reset();
        set_seq(32'b01, 2, 0, 0, 0, 0, 0, 0);
        run_seq();
        #2;
        hard_reset();
        set_seq(32'b100, 3, 0, 0, 0, 0, 0, 0);
        run_seq();
        peek("rst_nomatch", 2'd0, 0);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            drive(4'($urandom), 4'($urandom), ($urandom % 10) != 0,
                  ($urandom % 25) == 0, 4'($urandom),
                  ($urandom % 40) == 0, 2'($urandom));
            step(g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_ch_seq_sched.md
MULTI_CH_SEQ_SCHED -- requirements
Module: multi_ch_seq_sched

Interface
REQ-001 Parameter: none; channel count fixed at 4, pattern width fixed at 4.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 enable  input  1  1 = arbitration allowed; 0 = no grants, state held.
REQ-005 ch_valid  input  4  per-channel serial bit offered.
REQ-006 ch_bit  input  4  per-channel serial bit value, qualified by ch_valid[i].
REQ-007 ch_ready  output  4  one-hot grant; a bit transfers from channel i when ch_valid[i] & ch_ready[i].
REQ-008 cfg_we  input  1  pattern write strobe.
REQ-009 cfg_pattern  input  4  new pattern; [3] = oldest bit, [0] = newest bit.
REQ-010 cnt_clr  input  1  clear all match counters.
REQ-011 cnt_sel  input  2  channel index for counter readback.
REQ-012 match_valid  output  1  registered pulse: the bit accepted last cycle completed a match.
REQ-013 match_ch  output  2  channel of that match; valid only while match_valid = 1.
REQ-014 cnt_out  output  8  combinational readback of match counter[cnt_sel].

Function
REQ-015 The block SHALL time-share one 4-bit overlapping pattern-match engine among 4 serial channels, accepting at most one bit per cycle.
REQ-016 Per-channel context: 3-bit history hist[i] (newest bit in [0]) and 2-bit fill count fill[i] (0..3, saturating at 3).
REQ-017 Arbitration: round-robin over channels with ch_valid = 1; search starts at last_grant+1 mod 4; last_grant updates only on a transfer.
REQ-018 ch_ready SHALL be combinational from ch_valid, last_grant, enable and cfg_we, at most one bit set, and 0 when no channel is valid.
REQ-019 No grant SHALL occur when enable = 0 or cfg_we = 1; cfg_we takes priority over a same-cycle grant.
REQ-020 On transfer of bit b from channel i: the match SHALL be fill[i] == 3 and {hist[i], b} == pattern.
REQ-021 On the same transfer: hist[i] <= {hist[i][1:0], b}; fill[i] <= min(fill[i] + 1, 3); other channels unchanged.
REQ-022 Detection SHALL be overlapping; a match does not clear the history.
REQ-023 Match latency: transfer at cycle T -> match_valid = 1 and match_ch = i in cycle T+1 only; match_valid = 0 otherwise.
REQ-024 On a match, counter[i] SHALL increment by 1, saturating at 255.
REQ-025 cnt_clr SHALL zero all 4 counters next cycle; cnt_clr has priority over a same-cycle increment.
REQ-026 cfg_we SHALL load the pattern next cycle and clear fill[] of all channels; hist contents become don't-care.
REQ-027 cfg_we SHALL NOT affect the counters, last_grant, or a match_valid already in flight.
REQ-028 A channel holding ch_valid = 1 without a grant SHALL keep its bit; the block drops no accepted bit and accepts none twice.

Reset
REQ-029 On reset, the following SHALL hold:
- pattern = 4'b1001; hist = 0 and fill = 0 for all channels.
- last_grant = 3, so channel 0 has first priority.
- counters = 0; match_valid = 0; match_ch = 0.
REQ-030 ch_ready SHALL be 0 while reset is asserted.
REQ-031 Reset asserted mid-stream SHALL discard partial histories and any pending match_valid immediately (asynchronous).

Verification
REQ-032 Single channel, default pattern: ch0 streams 1,0,0,1,0,0,1 with only ch0 valid -> ch0 granted every cycle; match_valid with match_ch = 0 after the 4th and 7th bits; cnt_sel = 0 gives cnt_out = 2.
REQ-033 Fairness: all 4 valid continuously from reset -> grants in order ch0, ch1, ch2, ch3, ch0, ...; each channel's history is independent.
REQ-034 Interleaving: ch1 sends 1,0,0,1 while ch2 sends 1,1,1,1, both valid every cycle -> exactly one match on ch1 after its 4th accepted bit; none on ch2.
REQ-035 Reconfiguration: cfg_pattern = 4'b1111 mid-stream -> no grant that cycle; fill cleared; ch3 then sends 1 x6 -> matches on its 4th, 5th and 6th bits.
REQ-036 Counter saturation and clear: 300 matches on ch0 -> cnt_out = 255; cnt_clr together with a match -> cnt_out = 0 next cycle.
REQ-037 enable = 0 with all channels valid -> ch_ready = 0 and no state change; a reset pulse mid-pattern -> a subsequent 0,0,1 does not match.
